sha256_stream: RTL and testbench
================================

# sha256_stream

Parametrised multi-block SHA-256 engine for the mining datapath. It accepts pre-padded 512-bit message blocks over a valid/ready stream and chains any number of blocks per message. It computes 1, 2, 4 or 8 compression rounds per clock and returns the 256-bit digest over a valid/ready output. The message schedule is a rolling 16-word window rather than a full 64-word store, and an optional compile-time double-hash (SHA-256d) mode is provided for block-header hashing.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: compression rounds per clock. Legal values are 1, 2, 4, 8; any other value is a elaboration error.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `blk_valid`  in  1  `blk_data` and `blk_last` are valid.
- `blk_ready`  out  1  engine accepts a block this cycle.
- `blk_data`  in  512  pre-padded block; word 0 = bits [511:480].
- `blk_last`  in  1  block is the final block of its message.
- `hash_valid`  out  1  `hash` holds a finished digest.
- `hash_ready`  in  1  consumer takes the digest.
- `hash`  out  256  digest H0..H7, H0 = bits [255:224].
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ROUND, FINAL, WAIT, OUT.
- IDLE:
  - `blk_ready`=1.
  - On accept: load H0..H7 with the IV, a..h with the IV, and the W window with `blk_data`. Clear the round counter and go to ROUND.
- ROUND:
  - Performs R = `ROUNDS_PER_CYCLE` rounds per cycle using K[t..t+R-1].
  - For t<16, W[t] comes from the window. For t≥16, W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], generated into the window.
  - All additions are mod 2^32.
  - After 64/R cycles, go to FINAL.
- FINAL: H_i <= H_i + a..h (mod 2^32). Then:
  - If the current block was not the last, go to WAIT.
  - If it was the last, register `hash` and go to OUT.
- WAIT:
  - `blk_ready`=1.
  - On accept: a..h <= current H, load the window, go to ROUND.
  - `blk_last` of the accepted block is latched.
- OUT:
  - `hash_valid`=1 and `hash` is stable.
  - On `hash_ready`, go to IDLE.
  - `blk_ready`=0 while in OUT.
- `blk_ready` is 0 in ROUND, FINAL and OUT. Inputs are ignored unless `blk_valid`&&`blk_ready`.
- `blk_last` is sampled only on accept.

## Timing
- Reset values: `blk_ready`=0 during the reset cycle and 1 from the first post-reset cycle (IDLE). `hash_valid`=0, `hash`=0, `busy`=0.
- Per-block latency: accept edge, then 64/R ROUND cycles, then 1 FINAL cycle.
- Single-block message: `hash_valid` rises 64/R+2 edges after the accepting edge.
  - R=1: 66 cycles.
  - R=8: 10 cycles.
- Chained block: `blk_ready` rises in the cycle after FINAL. A block presented and held is accepted with zero extra stall.
- Throughput (single-block messages, `hash_ready` tied 1): one digest per 64/R+3 cycles.
- OUT with `hash_ready`=1 on its first cycle: `hash_valid` is high for exactly one cycle.
- Back-pressure: `hash_valid` and `hash` are held indefinitely while `hash_ready`=0. No new block is accepted.
- `rst` mid-operation:
  - Next cycle is IDLE, all outputs return to their reset values, and any partial message is discarded.
  - `rst` has priority over every handshake in the same cycle.

## Configuration
- Macro: `SHA256D_EN`.
- Defined: in FINAL of a last block, the engine does not enter OUT.
  - It re-seeds H and a..h with the IV.
  - It loads the window with {digest, 32'h80000000, 192'h0, 32'h00000100}, the 256-bit message padded to one block.
  - It runs ROUND/FINAL once more, then enters OUT with SHA-256(SHA-256(msg)).
  - Latency of a single-block message becomes 2·(64/R+1)+1.
  - `blk_ready` stays 0 throughout the second pass.
- Undefined: plain SHA-256. No second-pass logic or state is compiled in.

## Test plan
- R=1, block {32'h61626380, 416'h0, 64'h18} ("abc"), last=1, `hash_ready`=1:
  - `hash` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
  - `hash_valid` rises at cycle 66.
- R=4, two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (56 bytes), second block presented 5 cycles late:
  - `hash` = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- R=8, empty message {32'h80000000, 480'h0}, `hash_ready` low for 20 cycles:
  - `hash` = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, held stable.
  - `blk_ready`=0 for those 20 cycles.
- With `SHA256D_EN`, R=1, "abc" block:
  - `hash` = 4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358.
  - `hash_valid` rises at cycle 131.
- Assert `rst` 30 cycles into the first block of a two-block message, then send "abc":
  - All outputs go to their reset values on the next cycle.
  - The "abc" digest is correct, with no residue from the aborted message.
- R=2, back-to-back "abc" messages with `blk_valid` and `hash_ready` tied high:
  - Identical digests every 35 cycles.

Source files
------------

// File: rtl/sha256_stream.sv
// sha256_stream: multi-block SHA-256 engine, 1/2/4/8 rounds per clock, rolling 16-word schedule.
// Ports: clk, rst (synchronous, active-high)
//        blk_valid/blk_ready/blk_data[511:0]/blk_last : pre-padded block stream, word 0 = [511:480]
//        hash_valid/hash_ready/hash[255:0]             : digest stream, H0 = [255:224]
//        busy                                          : high whenever the engine is not idle
// Optional macro SHA256D_EN: after the last block, hash the 256-bit digest once more (SHA-256d).
module sha256_stream #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_last,
    output logic         hash_valid,
    input  logic         hash_ready,
    output logic [255:0] hash,
    output logic         busy
);
    localparam int R = ROUNDS_PER_CYCLE;
    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    typedef enum logic [2:0] {IDLE, ROUND, FINAL, WAIT, OUT} state_t;
    state_t state, nxt;

    logic [0:7][31:0]  hh, wk, nwk, dg;
    logic [0:15][31:0] w, nw;
    logic [31:0]       ext [0:15+R];
    logic [31:0]       a, b, c, d, e, f, g, h, t1, t2;
    logic [5:0]        rnd;
    logic              last_q, accept;
`ifdef SHA256D_EN
    logic              pass2;
`endif

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign blk_ready  = !rst && (state == IDLE || state == WAIT);
    assign accept     = blk_valid && blk_ready;
    assign hash_valid = state == OUT;
    assign busy       = state != IDLE;

    // Window holds W[t..t+15]; ext appends the R words that slide in this cycle.
    always_comb begin
        for (int i = 0; i < 16; i++) ext[i] = w[i];
        for (int j = 0; j < R; j++) ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
        for (int i = 0; i < 16; i++) nw[i] = ext[R+i];
        {a, b, c, d, e, f, g, h} = wk;
        t1 = '0;
        t2 = '0;
        for (int j = 0; j < R; j++) begin
            t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + K[rnd + 6'(j)] + ext[j];
            t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        nwk = {a, b, c, d, e, f, g, h};
        for (int i = 0; i < 8; i++) dg[i] = hh[i] + wk[i];
    end

    always_ff @(posedge clk) state <= rst ? IDLE : nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? ROUND : IDLE;
            ROUND:   nxt = (rnd == 6'(64 - R)) ? FINAL : ROUND;
`ifdef SHA256D_EN
            FINAL:   nxt = !last_q ? WAIT : (pass2 ? OUT : ROUND);
`else
            FINAL:   nxt = last_q ? OUT : WAIT;
`endif
            WAIT:    nxt = accept ? ROUND : WAIT;
            OUT:     nxt = hash_ready ? IDLE : OUT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hash   <= '0;
            last_q <= 1'b0;
            rnd    <= '0;
`ifdef SHA256D_EN
            pass2  <= 1'b0;
`endif
        end else if (accept) begin
            w      <= blk_data;
            rnd    <= '0;
            last_q <= blk_last;
            hh     <= (state == IDLE) ? IV : hh;
            wk     <= (state == IDLE) ? IV : hh;
`ifdef SHA256D_EN
            pass2  <= 1'b0;
`endif
        end else if (state == ROUND) begin
            w   <= nw;
            wk  <= nwk;
            rnd <= rnd + 6'(R);
        end else if (state == FINAL) begin
            hh <= dg;
`ifdef SHA256D_EN
            // Second pass: the first digest, padded as a 256-bit message, becomes the next block.
            if (last_q && !pass2) begin
                hh    <= IV;
                wk    <= IV;
                w     <= {dg, 32'h80000000, 192'h0, 32'h00000100};
                rnd   <= '0;
                pass2 <= 1'b1;
            end else if (last_q) begin
                hash <= dg;
            end
`else
            if (last_q) hash <= dg;
`endif
        end
    end
endmodule

// File: tb/tb_sha256_stream.sv
// tb_sha256_stream: directed checks of sha256_stream at R=1,2,4,8 against a reference SHA-256 model.
module tb_sha256_stream;
    localparam int NI = 4;
    localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] ABC     = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] EMPTY   = {32'h80000000, 480'h0};
    localparam logic [511:0] TB0     = {256'h6162636462636465636465666465666765666768666768696768696a68696a6b,
                                        192'h696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071, 64'h8000000000000000};
    localparam logic [511:0] TB1     = {448'h0, 64'h1c0};
    localparam logic [255:0] ABC_H   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_H   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] EMPTY_H = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] ABC_DH  = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
`ifdef SHA256D_EN
    localparam bit           PLAIN   = 1'b0;
    localparam logic [255:0] ABC_EXP = ABC_DH;
`else
    localparam bit           PLAIN   = 1'b1;
    localparam logic [255:0] ABC_EXP = ABC_H;
`endif
    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         blk_valid [NI], blk_ready [NI], blk_last [NI], hash_valid [NI], hash_ready [NI], busy [NI];
    logic [511:0] blk_data [NI];
    logic [255:0] hash [NI], exp_h [NI];
    int           checks = 0, errs = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sha256_stream #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk(clk), .rst(rst),
            .blk_valid(blk_valid[g]), .blk_ready(blk_ready[g]), .blk_data(blk_data[g]), .blk_last(blk_last[g]),
            .hash_valid(hash_valid[g]), .hash_ready(hash_ready[g]), .hash(hash[g]), .busy(busy[g])
        );
    end

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-word schedule, then 64 rounds, then feed-forward.
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] wd [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) wd[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(wd[t-15], 7) ^ ror(wd[t-15], 18) ^ (wd[t-15] >> 3);
            s1 = ror(wd[t-2], 17) ^ ror(wd[t-2], 19) ^ (wd[t-2] >> 10);
            wd[t] = s1 + wd[t-7] + s0 + wd[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + wd[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int k = 7; k > 0; k--) v[k] = v[k-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [255:0] expect_msg(input int nb, input logic [511:0] b0, input logic [511:0] b1);
        logic [255:0] hv;
        hv = compress(IV, b0);
        if (nb == 2) hv = compress(hv, b1);
`ifdef SHA256D_EN
        hv = compress(IV, {hv, 32'h80000000, 192'h0, 32'h00000100});
`endif
        return hv;
    endfunction

    function automatic int lat_of(input int r);
`ifdef SHA256D_EN
        return 2 * (64 / r + 1) + 1;
`else
        return 64 / r + 2;
`endif
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] want);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Every cycle a digest is offered it must equal the model's digest for that instance.
    always @(negedge clk)
        if (!rst)
            for (int i = 0; i < NI; i++)
                if (hash_valid[i]) chk(hash[i] == exp_h[i], "hash_vs_model", hash[i], exp_h[i]);

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic present(input int i, input logic [511:0] dat, input logic l);
        int n = 0;
        blk_valid[i] = 1'b1;
        blk_data[i]  = dat;
        blk_last[i]  = l;
        while (!blk_ready[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(blk_ready[i], "accept_timeout", 256'(blk_ready[i]), 256'd1);
        @(negedge clk);
        blk_valid[i] = 1'b0;
    endtask

    task automatic run_msg(input int i, input int nb, input logic [511:0] b0, input logic [511:0] b1,
                           input int gap, input int hold, input bit use_lit, input logic [255:0] lit);
        int k;
        exp_h[i]      = expect_msg(nb, b0, b1);
        hash_ready[i] = (hold == 0);
        present(i, b0, nb == 1);
        if (nb == 2) begin
            k = 1;
            while (!blk_ready[i] && k < 300) begin
                @(negedge clk);
                k++;
            end
            chk(k == 64 / (1 << i) + 2, "chain_ready_cycle", 256'(k), 256'(64 / (1 << i) + 2));
            repeat (gap) @(negedge clk);
            present(i, b1, 1'b1);
        end
        k = 1;
        while (!hash_valid[i] && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(k == lat_of(1 << i), "hash_latency", 256'(k), 256'(lat_of(1 << i)));
        if (use_lit) chk(hash[i] == lit, "hash_literal", hash[i], lit);
        blk_valid[i] = hold > 0;
        for (int n = 0; n < hold; n++) begin
            chk(hash_valid[i] && !blk_ready[i], "hold_stall", {hash_valid[i], blk_ready[i]}, 256'b10);
            @(negedge clk);
        end
        hash_ready[i] = 1'b1;
        blk_valid[i]  = 1'b0;
        @(negedge clk);
        chk(!hash_valid[i] && !busy[i], "out_release", {hash_valid[i], busy[i]}, 256'b0);
    endtask

    initial begin
        int prev, seen, n;
        bit hv_d;
        for (int i = 0; i < NI; i++) begin
            blk_valid[i]  = 1'b0;
            blk_last[i]   = 1'b0;
            blk_data[i]   = '0;
            hash_ready[i] = 1'b1;
            exp_h[i]      = '0;
        end
        chk(compress(IV, ABC) == ABC_H, "model_abc", compress(IV, ABC), ABC_H);
        chk(compress(compress(IV, TB0), TB1) == TWO_H, "model_two_block", compress(compress(IV, TB0), TB1), TWO_H);
        chk(compress(IV, EMPTY) == EMPTY_H, "model_empty", compress(IV, EMPTY), EMPTY_H);
        chk(expect_msg(1, ABC, '0) == ABC_EXP, "model_abc_expect", expect_msg(1, ABC, '0), ABC_EXP);

        @(negedge clk);
        for (int i = 0; i < NI; i++) chk(!blk_ready[i], "ready_in_reset", 256'(blk_ready[i]), 256'd0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk(blk_ready[i] && !hash_valid[i] && hash[i] == '0 && !busy[i], "post_reset",
                {blk_ready[i], hash_valid[i], busy[i], hash[i][31:0]}, {3'b100, 32'h0});

        run_msg(0, 1, ABC, '0, 0, 0, 1'b1, ABC_EXP);
        run_msg(2, 2, TB0, TB1, 5, 0, PLAIN, TWO_H);
        run_msg(3, 1, EMPTY, '0, 0, 20, PLAIN, EMPTY_H);

        present(0, TB0, 1'b0);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk(!blk_ready[i] && !hash_valid[i] && hash[i] == '0 && !busy[i], "mid_reset",
                {blk_ready[i], hash_valid[i], busy[i], hash[i][31:0]}, 256'h0);
        rst = 1'b0;
        @(negedge clk);
        chk(blk_ready[0] && !busy[0], "idle_after_reset", {blk_ready[0], busy[0]}, 256'b10);
        run_msg(0, 1, ABC, '0, 0, 0, 1'b1, ABC_EXP);

        exp_h[1]      = expect_msg(1, ABC, '0);
        blk_data[1]   = ABC;
        blk_last[1]   = 1'b1;
        hash_ready[1] = 1'b1;
        blk_valid[1]  = 1'b1;
        prev = -1;
        seen = 0;
        n    = 0;
        hv_d = 1'b0;
        while (seen < 4 && n < 400) begin
            @(negedge clk);
            n++;
            if (hash_valid[1] && !hv_d) begin
                if (prev >= 0) chk(n - prev == lat_of(2) + 1, "b2b_period", 256'(n - prev), 256'(lat_of(2) + 1));
                prev = n;
                seen++;
            end
            hv_d = hash_valid[1];
        end
        chk(seen == 4, "b2b_digest_count", 256'(seen), 256'd4);
        blk_valid[1] = 1'b0;
        repeat (150) @(negedge clk);
        chk(!busy[1], "b2b_drain", 256'(busy[1]), 256'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
